// File: rtl/cache_port_scheduler_pkg.sv
// rtl/cache_port_scheduler_pkg.sv - shared widths, requester encoding and helpers for the cache port scheduler
package cache_port_scheduler_pkg;

    localparam int CACHE_SCHED_NUM_REQ      = 5;
    localparam int CACHE_BANK_ADDRESS_WIDTH = 8;
    localparam int DATA_WIDTH               = 16;
    localparam int NETWORK_ADDRESS_WIDTH    = 4;
    localparam int CACHE_SCHED_IDX_W        = 3;

    typedef enum logic [2:0] {
        REQ_NORTH = 3'd0,
        REQ_SOUTH = 3'd1,
        REQ_EAST  = 3'd2,
        REQ_WEST  = 3'd3,
        REQ_LOCAL = 3'd4
    } reqIndexT;

    // Increment with wrap back to zero at modulus.
    function automatic int wrapInc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/cache_port_scheduler_if.sv
// rtl/cache_port_scheduler_if.sv - requester request/grant bus and tagged read responses
interface cache_port_scheduler_if
    import cache_port_scheduler_pkg::*;
#(
    parameter int NUM_REQ = CACHE_SCHED_NUM_REQ,
    parameter int ADDR_W  = CACHE_BANK_ADDRESS_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int NET_W   = NETWORK_ADDRESS_WIDTH,
    parameter int IDX_W   = CACHE_SCHED_IDX_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*NET_W-1:0]  req_requester;
    logic [NUM_REQ-1:0]        req_ready;

    logic              rspA_valid;
    logic [IDX_W-1:0]  rspA_idx;
    logic [NET_W-1:0]  rspA_requester;
    logic [DATA_W-1:0] rspA_data;
    logic              rspB_valid;
    logic [IDX_W-1:0]  rspB_idx;
    logic [NET_W-1:0]  rspB_requester;
    logic [DATA_W-1:0] rspB_data;

    modport master (
        output req_valid, req_write, req_addr, req_data, req_requester,
        input  req_ready,
        input  rspA_valid, rspA_idx, rspA_requester, rspA_data,
        input  rspB_valid, rspB_idx, rspB_requester, rspB_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, req_requester,
        output req_ready,
        output rspA_valid, rspA_idx, rspA_requester, rspA_data,
        output rspB_valid, rspB_idx, rspB_requester, rspB_data
    );
endinterface

// File: rtl/cache_port_scheduler_rr_pick.sv
// rtl/cache_port_scheduler_rr_pick.sv - rotate-priority first-one finder with exclusion mask
module cache_port_scheduler_rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_REQ-1:0] candidates,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   startPtr,
    output logic               found,
    output logic [IDX_W-1:0]   pickIdx,
    output logic [NUM_REQ-1:0] pickOneHot
);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W:0]     slot;

    assign eligible = candidates & ~mask;

    // Walk from startPtr upward, wrapping, and take the first eligible requester.
    always_comb begin
        found      = 1'b0;
        pickIdx    = '0;
        pickOneHot = '0;
        slot       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            slot = {1'b0, startPtr} + (IDX_W + 1)'(k);
            if (slot >= NUM_REQ_W) begin
                slot = slot - NUM_REQ_W;
            end
            if (!found && eligible[slot[IDX_W-1:0]]) begin
                found                         = 1'b1;
                pickIdx                       = slot[IDX_W-1:0];
                pickOneHot[slot[IDX_W-1:0]]   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_port_scheduler.sv
// rtl/cache_port_scheduler.sv - two-port round-robin cache bank scheduler with tagged read responses
module cache_port_scheduler
    import cache_port_scheduler_pkg::*;
#(
    parameter int NUM_REQ = CACHE_SCHED_NUM_REQ,
    parameter int ADDR_W  = CACHE_BANK_ADDRESS_WIDTH,
    parameter int DATA_W  = DATA_WIDTH,
    parameter int NET_W   = NETWORK_ADDRESS_WIDTH,
    parameter int IDX_W   = CACHE_SCHED_IDX_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_port_scheduler_if.slave bus,
    output logic [ADDR_W-1:0]    cacheAddressIn_A,
    output logic [ADDR_W-1:0]    cacheAddressIn_B,
    output logic [DATA_W-1:0]    cacheDataIn_A,
    output logic [DATA_W-1:0]    cacheDataIn_B,
    output logic                 memWrite_A,
    output logic                 memWrite_B,
    input  logic [DATA_W-1:0]    cacheDataOut_A,
    input  logic [DATA_W-1:0]    cacheDataOut_B,
    output logic [15:0]          stat_conflicts
);
    logic [IDX_W-1:0]   rrPtr, nextPtr, lastIdx;
    logic               foundA, foundB, hasConflict;
    logic [IDX_W-1:0]   idxA, idxB;
    logic [NUM_REQ-1:0] oneHotA, oneHotB, conflictMask, maskB;
    logic [ADDR_W-1:0]  addrA, addrB;
    logic [DATA_W-1:0]  dataA, dataB;
    logic [NET_W-1:0]   whoA, whoB;
    logic               writeA, writeB;

    logic               tagValidA1, tagValidA2, tagValidB1, tagValidB2;
    logic [IDX_W-1:0]   tagIdxA1, tagIdxA2, tagIdxB1, tagIdxB2;
    logic [NET_W-1:0]   tagWhoA1, tagWhoA2, tagWhoB1, tagWhoB2;

    cache_port_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) pickA (
        .candidates (bus.req_valid),
        .mask       ({NUM_REQ{1'b0}}),
        .startPtr   (rrPtr),
        .found      (foundA),
        .pickIdx    (idxA),
        .pickOneHot (oneHotA)
    );

    assign maskB = oneHotA | conflictMask;

    cache_port_scheduler_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) pickB (
        .candidates (bus.req_valid),
        .mask       (maskB),
        .startPtr   (rrPtr),
        .found      (foundB),
        .pickIdx    (idxB),
        .pickOneHot (oneHotB)
    );

    // Fetch the port A request fields and mark B candidates that collide with it.
    always_comb begin
        addrA        = '0;
        dataA        = '0;
        whoA         = '0;
        writeA       = 1'b0;
        conflictMask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oneHotA[i]) begin
                addrA  = bus.req_addr[i*ADDR_W +: ADDR_W];
                dataA  = bus.req_data[i*DATA_W +: DATA_W];
                whoA   = bus.req_requester[i*NET_W +: NET_W];
                writeA = bus.req_write[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            conflictMask[i] = foundA && bus.req_valid[i] && !oneHotA[i]
                              && (bus.req_addr[i*ADDR_W +: ADDR_W] == addrA)
                              && (bus.req_write[i] || writeA);
        end
    end

    // Fetch the port B request fields.
    always_comb begin
        addrB  = '0;
        dataB  = '0;
        whoB   = '0;
        writeB = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oneHotB[i]) begin
                addrB  = bus.req_addr[i*ADDR_W +: ADDR_W];
                dataB  = bus.req_data[i*DATA_W +: DATA_W];
                whoB   = bus.req_requester[i*NET_W +: NET_W];
                writeB = bus.req_write[i];
            end
        end
    end

    assign hasConflict   = |conflictMask;
    assign lastIdx       = foundB ? idxB : idxA;
    assign nextPtr       = IDX_W'(wrapInc(int'(lastIdx), NUM_REQ));
    assign bus.req_ready = reset ? {NUM_REQ{1'b0}} : (oneHotA | oneHotB);

    // Advance the round-robin pointer past the last grant and count blocked B candidates.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr          <= '0;
            stat_conflicts <= '0;
        end else begin
            if (foundA) begin
                rrPtr <= nextPtr;
            end
            if (hasConflict && stat_conflicts != 16'hFFFF) begin
                stat_conflicts <= stat_conflicts + 16'd1;
            end
        end
    end

    // Port A issue registers and its read tag pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cacheAddressIn_A <= '0;
            cacheDataIn_A    <= '0;
            memWrite_A       <= 1'b0;
            tagValidA1       <= 1'b0;
            tagIdxA1         <= '0;
            tagWhoA1         <= '0;
            tagValidA2       <= 1'b0;
            tagIdxA2         <= '0;
            tagWhoA2         <= '0;
        end else begin
            memWrite_A <= foundA && writeA;
            if (foundA) begin
                cacheAddressIn_A <= addrA;
                cacheDataIn_A    <= dataA;
            end
            tagValidA1 <= foundA && !writeA;
            tagIdxA1   <= idxA;
            tagWhoA1   <= whoA;
            tagValidA2 <= tagValidA1;
            tagIdxA2   <= tagIdxA1;
            tagWhoA2   <= tagWhoA1;
        end
    end

    // Port B issue registers and its read tag pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cacheAddressIn_B <= '0;
            cacheDataIn_B    <= '0;
            memWrite_B       <= 1'b0;
            tagValidB1       <= 1'b0;
            tagIdxB1         <= '0;
            tagWhoB1         <= '0;
            tagValidB2       <= 1'b0;
            tagIdxB2         <= '0;
            tagWhoB2         <= '0;
        end else begin
            memWrite_B <= foundB && writeB;
            if (foundB) begin
                cacheAddressIn_B <= addrB;
                cacheDataIn_B    <= dataB;
            end
            tagValidB1 <= foundB && !writeB;
            tagIdxB1   <= idxB;
            tagWhoB1   <= whoB;
            tagValidB2 <= tagValidB1;
            tagIdxB2   <= tagIdxB1;
            tagWhoB2   <= tagWhoB1;
        end
    end

    assign bus.rspA_valid     = tagValidA2;
    assign bus.rspA_idx       = tagIdxA2;
    assign bus.rspA_requester = tagWhoA2;
    assign bus.rspA_data      = cacheDataOut_A;
    assign bus.rspB_valid     = tagValidB2;
    assign bus.rspB_idx       = tagIdxB2;
    assign bus.rspB_requester = tagWhoB2;
    assign bus.rspB_data      = cacheDataOut_B;
endmodule

// File: tb/tb_cache_port_scheduler.sv
// tb/tb_cache_port_scheduler.sv - scoreboard bench for the cache port scheduler
module tb_cache_port_scheduler;
    localparam int NR = 5;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [3:0]  who;
    } reqT;

    typedef struct packed {
        logic [2:0]  idx;
        logic [3:0]  who;
        logic [15:0] data;
    } expT;

    logic        clk;
    logic        reset;
    logic [7:0]  cacheAddressIn_A, cacheAddressIn_B;
    logic [15:0] cacheDataIn_A, cacheDataIn_B;
    logic        memWrite_A, memWrite_B;
    logic [15:0] cacheDataOut_A, cacheDataOut_B;
    logic [15:0] stat_conflicts;

    logic        preWr;
    logic [7:0]  preAddr;
    logic [15:0] preData;
    logic [15:0] bankMem [256];
    logic [15:0] gold [256];

    reqT  pend [NR][8];
    int   head [NR];
    int   cnt [NR];
    expT  expA[$];
    expT  expB[$];
    int   mPtr;
    logic [15:0] mConf;
    bit   randMode, satMode;
    int   nVec, nMis;

    cache_port_scheduler_if #(.NUM_REQ(5), .ADDR_W(8), .DATA_W(16), .NET_W(4), .IDX_W(3)) bus ();

    cache_port_scheduler #(.NUM_REQ(5), .ADDR_W(8), .DATA_W(16), .NET_W(4), .IDX_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (bus),
        .cacheAddressIn_A (cacheAddressIn_A),
        .cacheAddressIn_B (cacheAddressIn_B),
        .cacheDataIn_A    (cacheDataIn_A),
        .cacheDataIn_B    (cacheDataIn_B),
        .memWrite_A       (memWrite_A),
        .memWrite_B       (memWrite_B),
        .cacheDataOut_A   (cacheDataOut_A),
        .cacheDataOut_B   (cacheDataOut_B),
        .stat_conflicts   (stat_conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-port synchronous bank: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (preWr) begin
            bankMem[preAddr] <= preData;
        end else begin
            if (memWrite_A) bankMem[cacheAddressIn_A] <= cacheDataIn_A;
            if (memWrite_B) bankMem[cacheAddressIn_B] <= cacheDataIn_B;
        end
        cacheDataOut_A <= bankMem[cacheAddressIn_A];
        cacheDataOut_B <= bankMem[cacheAddressIn_B];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pushReq(input int i, input logic wr, input logic [7:0] addr,
                           input logic [15:0] data, input logic [3:0] who);
        reqT r;
        r.wr = wr; r.addr = addr; r.data = data; r.who = who;
        pend[i][(head[i] + cnt[i]) % 8] = r;
        cnt[i]++;
    endtask

    task automatic popHead(input int i);
        head[i] = (head[i] + 1) % 8;
        cnt[i]--;
    endtask

    task automatic driveHeads();
        logic [4:0]  v, w;
        logic [39:0] a;
        logic [79:0] d;
        logic [19:0] n;
        reqT r;
        v = '0; w = '0; a = '0; d = '0; n = '0;
        for (int i = 0; i < NR; i++) begin
            if (cnt[i] > 0) begin
                r = pend[i][head[i]];
                v[i] = 1'b1;
                w[i] = r.wr;
                a[i*8 +: 8]   = r.addr;
                d[i*16 +: 16] = r.data;
                n[i*4 +: 4]   = r.who;
            end
        end
        bus.req_valid = v; bus.req_write = w; bus.req_addr = a;
        bus.req_data = d; bus.req_requester = n;
    endtask

    // Reference arbitration: list the valid requesters in rotated order, A is the first,
    // B the first later one that does not collide with A.
    task automatic modelStep();
        int order[$];
        int a, b;
        bit conf;
        reqT ra, r, rb;
        expT e;
        logic [4:0] expReady;
        expReady = '0;
        for (int k = 0; k < NR; k++) begin
            if (cnt[(mPtr + k) % NR] > 0) order.push_back((mPtr + k) % NR);
        end
        if (order.size() > 0) begin
            a = order[0];
            ra = pend[a][head[a]];
            b = -1;
            conf = 0;
            for (int j = 1; j < order.size(); j++) begin
                r = pend[order[j]][head[order[j]]];
                if (r.addr == ra.addr && (r.wr || ra.wr)) conf = 1;
                else if (b < 0) b = order[j];
            end
            expReady[a] = 1'b1;
            if (!ra.wr) begin
                e.idx = 3'(a); e.who = ra.who; e.data = gold[ra.addr];
                expA.push_back(e);
            end
            if (b >= 0) begin
                expReady[b] = 1'b1;
                rb = pend[b][head[b]];
                if (!rb.wr) begin
                    e.idx = 3'(b); e.who = rb.who; e.data = gold[rb.addr];
                    expB.push_back(e);
                end else begin
                    gold[rb.addr] = rb.data;
                end
            end
            if (ra.wr) gold[ra.addr] = ra.data;
            mPtr = ((b >= 0 ? b : a) + 1) % NR;
            if (conf && mConf != 16'hFFFF) mConf = mConf + 16'd1;
            popHead(a);
            if (b >= 0) popHead(b);
        end
        chk("req_ready", 64'(bus.req_ready), 64'(expReady));
    endtask

    task automatic refill();
        for (int i = 0; i < NR; i++) begin
            if (randMode && cnt[i] == 0 && $urandom_range(1, 0) == 1)
                pushReq(i, $urandom_range(2, 0) == 0, 8'($urandom_range(7, 0)),
                        16'($urandom), 4'($urandom));
        end
        if (satMode) begin
            if (cnt[0] == 0) pushReq(0, 1'b1, 8'h20, 16'($urandom), 4'h0);
            if (cnt[1] == 0) pushReq(1, 1'b0, 8'h20, 16'h0, 4'h1);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (reset) chk("ready_in_reset", 64'(bus.req_ready), 64'h0);
        else modelStep();
        @(posedge clk);
        #1;
        refill();
        driveHeads();
    endtask

    task automatic flushModel();
        expA.delete();
        expB.delete();
        mPtr = 0;
        mConf = 16'h0;
        for (int i = 0; i < NR; i++) begin head[i] = 0; cnt[i] = 0; end
    endtask

    task automatic doReset();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        driveHeads();
        step();
        flushModel();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int c = 0; c < 40; c++) begin
            left = 0;
            for (int i = 0; i < NR; i++) left += cnt[i];
            if (left == 0) break;
            step();
        end
        left = 0;
        for (int i = 0; i < NR; i++) left += cnt[i];
        chk("drain_pending", 64'(left), 64'h0);
        repeat (4) step();
        chk("expA_drained", 64'(expA.size()), 64'h0);
        chk("expB_drained", 64'(expB.size()), 64'h0);
    endtask

    // Response monitor: every presented read response must match the oldest expectation.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (bus.rspA_valid) begin
                if (expA.size() == 0) chk("rspA_unexpected", 64'h1, 64'h0);
                else begin
                    e = expA.pop_front();
                    chk("rspA", 64'({bus.rspA_idx, bus.rspA_requester, bus.rspA_data}), 64'(e));
                end
            end
            if (bus.rspB_valid) begin
                if (expB.size() == 0) chk("rspB_unexpected", 64'h1, 64'h0);
                else begin
                    e = expB.pop_front();
                    chk("rspB", 64'({bus.rspB_idx, bus.rspB_requester, bus.rspB_data}), 64'(e));
                end
            end
        end
    end

    initial begin
        nVec = 0; nMis = 0;
        randMode = 0; satMode = 0;
        reset = 1'b1;
        preWr = 1'b0; preAddr = '0; preData = '0;
        flushModel();
        driveHeads();
        for (int a = 0; a < 256; a++) gold[a] = 16'($urandom);
        gold[8'h10] = 16'hCAFE;
        for (int a = 0; a < 256; a++) begin
            preWr = 1'b1; preAddr = 8'(a); preData = gold[a];
            @(posedge clk);
            #1;
        end
        preWr = 1'b0;
        doReset();

        // Reset while a read is in flight.
        pushReq(0, 1'b0, 8'h55, 16'h0, 4'h3);
        driveHeads();
        step();
        reset = 1'b1;
        step();
        flushModel();
        chk("rst_rspA_valid", 64'(bus.rspA_valid), 64'h0);
        chk("rst_rspB_valid", 64'(bus.rspB_valid), 64'h0);
        chk("rst_addrA", 64'(cacheAddressIn_A), 64'h0);
        chk("rst_memWrite", 64'({memWrite_A, memWrite_B}), 64'h0);
        chk("rst_stat", 64'(stat_conflicts), 64'h0);
        step();
        reset = 1'b0;

        // Single read.
        pushReq(2, 1'b0, 8'h10, 16'h0, 4'h5);
        driveHeads();
        #1 chk("single_ready", 64'(bus.req_ready), 64'h04);
        step();
        chk("single_addrA", 64'(cacheAddressIn_A), 64'h10);
        step();
        chk("single_rsp", 64'({bus.rspA_valid, bus.rspA_idx, bus.rspA_requester, bus.rspA_data}),
            64'({1'b1, 3'd2, 4'h5, 16'hCAFE}));
        drain();

        // Round robin over all five.
        doReset();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 3; k++) pushReq(i, 1'b0, 8'(8'h80 + i * 4 + k), 16'h0, 4'(i));
        driveHeads();
        #1 chk("rr_grant0", 64'(bus.req_ready), 64'h03);
        step();
        #1 chk("rr_grant1", 64'(bus.req_ready), 64'h0C);
        step();
        #1 chk("rr_grant2", 64'(bus.req_ready), 64'h11);
        step();
        drain();

        // Write/read conflict on the same address.
        doReset();
        pushReq(0, 1'b1, 8'h20, 16'hBEEF, 4'h0);
        pushReq(1, 1'b0, 8'h20, 16'h0, 4'h1);
        pushReq(2, 1'b0, 8'h30, 16'h0, 4'h2);
        driveHeads();
        #1 chk("conf_grant0", 64'(bus.req_ready), 64'h05);
        step();
        #1 chk("conf_grant1", 64'(bus.req_ready), 64'h02);
        step();
        drain();
        chk("conf_stat", 64'(stat_conflicts), 64'h1);

        // Two reads to one address share the cycle.
        pushReq(3, 1'b0, 8'h40, 16'h0, 4'h3);
        pushReq(4, 1'b0, 8'h40, 16'h0, 4'h4);
        driveHeads();
        #1 chk("rr_same_grant", 64'(bus.req_ready), 64'h18);
        step();
        drain();
        chk("rr_same_stat", 64'(stat_conflicts), 64'h1);

        // Randomized traffic.
        randMode = 1;
        repeat (3000) step();
        randMode = 0;
        drain();
        chk("rand_stat", 64'(stat_conflicts), 64'(mConf));

        // Saturation of the conflict counter.
        doReset();
        satMode = 1;
        repeat (70000) step();
        satMode = 0;
        drain();
        chk("sat_stat", 64'(stat_conflicts), 64'hFFFF);
        chk("sat_model", 64'(stat_conflicts), 64'(mConf));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end
endmodule
